// File: rtl/hazard_pkg.sv
// Shared stage indices and sizing helpers for the
// hazard/forwarding controller.
package hazard_pkg;

    localparam int RA_W_DEF = 5;

    typedef enum logic [2:0] {
        STG_F  = 3'd0,
        STG_F2 = 3'd1,
        STG_D  = 3'd2,
        STG_E  = 3'd3
    } stg_e;

    function automatic int fwd_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// Per-operand forwarding picker: youngest matching writer
// wins, and reports whether that writer's result is usable yet.
module hazard_fwd_pick
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 4,
    parameter int RA_W    = RA_W_DEF,
    parameter int FW      = fwd_w(NUM_FWD)
) (
    input  logic [RA_W-1:0]         i_src,
    input  logic [NUM_FWD-1:0]      i_regwrite,
    input  logic [NUM_FWD*RA_W-1:0] i_writereg,
    input  logic [NUM_FWD-1:0]      i_rdy,
    output logic [FW-1:0]           o_sel,
    output logic                    o_not_ready
);

    always_comb begin
        o_sel       = '0;
        o_not_ready = 1'b0;
        // Oldest first so the youngest match overwrites.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_regwrite[k] && (i_src != '0) &&
                (i_writereg[k*RA_W +: RA_W] == i_src)) begin
                o_sel       = FW'(k + 1);
                o_not_ready = ~i_rdy[k];
            end
        end
    end

endmodule

// File: rtl/hazard_sb_unit.sv
// Hazard/forwarding controller with long-latency scoreboard,
// latched fetch redirect and saturating stall counter.
module hazard_sb_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 4,
    parameter int NUM_SRC = 2,
    parameter int RA_W    = RA_W_DEF,
    parameter int CNT_W   = 32
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               i_cache_stall,
    input  logic                               d_cache_stall,
    input  logic                               alu_stallE,
    input  logic [NUM_SRC*RA_W-1:0]            src_regD,
    input  logic [NUM_SRC-1:0]                 src_useD,
    input  logic [NUM_FWD-1:0]                 stg_regwrite,
    input  logic [NUM_FWD*RA_W-1:0]            stg_writereg,
    input  logic [NUM_FWD-1:0]                 stg_rdy,
    input  logic                               lop_issue,
    input  logic [RA_W-1:0]                    lop_dest,
    input  logic                               lop_done,
    input  logic [RA_W-1:0]                    lop_done_dest,
    input  logic                               redirectD,
    input  logic                               flush_jump_conflictE,
    input  logic                               flush_pred_failedM,
    input  logic                               flush_exceptionM,
    output logic [NUM_SRC*fwd_w(NUM_FWD)-1:0]  fwd_sel,
    output logic [NUM_FWD+2:0]                 stall_vec,
    output logic [NUM_FWD+2:0]                 flush_vec,
    output logic                               stall_d_data,
    output logic [CNT_W-1:0]                   stall_cnt
);

    localparam int FW    = fwd_w(NUM_FWD);
    localparam int NREG  = 1 << RA_W;
    localparam int W_IDX = NUM_FWD + 2;

    logic [NREG-1:0]    r_sb_busy;
    logic               r_redir_pend;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [NREG-1:0]    w_sb_next;
    logic [NUM_SRC-1:0] w_not_ready;
    logic [NUM_SRC-1:0] w_haz;
    logic               w_mem_stall;
    logic               w_stall_fe;
    logic               w_redir_req;
    logic               w_exc_pf;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_pick #(
            .NUM_FWD (NUM_FWD),
            .RA_W    (RA_W),
            .FW      (FW)
        ) u_pick (
            .i_src       (src_regD[i*RA_W +: RA_W]),
            .i_regwrite  (stg_regwrite),
            .i_writereg  (stg_writereg),
            .i_rdy       (stg_rdy),
            .o_sel       (fwd_sel[i*FW +: FW]),
            .o_not_ready (w_not_ready[i])
        );
        assign w_haz[i] = src_useD[i] &
            (w_not_ready[i] | r_sb_busy[src_regD[i*RA_W +: RA_W]]);
    end

    assign w_exc_pf     = flush_exceptionM | flush_pred_failedM;
    assign w_mem_stall  = i_cache_stall | d_cache_stall | alu_stallE;
    assign stall_d_data = (|w_haz) & ~w_exc_pf;
    assign w_stall_fe   = (w_mem_stall | stall_d_data) & ~flush_exceptionM;
    assign w_redir_req  = redirectD | flush_jump_conflictE;
    assign stall_cnt    = r_stall_cnt;

    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        stall_vec[STG_F]  = w_stall_fe;
        stall_vec[STG_F2] = w_stall_fe;
        stall_vec[STG_D]  = w_mem_stall | stall_d_data;
        for (int k = 0; k < NUM_FWD; k++) begin
            stall_vec[int'(STG_E) + k] = w_mem_stall;
        end
        stall_vec[W_IDX] = w_mem_stall & ~flush_exceptionM;

        // A redirect seen during a fetch stall is replayed here.
        flush_vec[STG_F2] = (w_redir_req | r_redir_pend) & ~w_stall_fe;
        flush_vec[STG_D]  = flush_jump_conflictE & ~w_mem_stall;
        flush_vec[STG_E]  = stall_d_data & ~w_mem_stall;
        if (flush_pred_failedM) begin
            flush_vec[STG_F2] = 1'b1;
            flush_vec[STG_D]  = 1'b1;
            if (!w_mem_stall) begin
                flush_vec[STG_E] = 1'b1;
            end
        end
        if (flush_exceptionM) begin
            for (int k = 1; k < W_IDX; k++) begin
                flush_vec[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sb_next = r_sb_busy;
        if (lop_done) begin
            w_sb_next[lop_done_dest] = 1'b0;
        end
        if (lop_issue) begin
            w_sb_next[lop_dest] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sb_busy    <= '0;
            r_redir_pend <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_sb_busy <= w_sb_next;
            if (w_exc_pf) begin
                r_redir_pend <= 1'b0;
            end else if (w_stall_fe) begin
                r_redir_pend <= r_redir_pend | w_redir_req;
            end else begin
                r_redir_pend <= 1'b0;
            end
            if (stall_vec[STG_D] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
